// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM-like data-port arbiter: size encodings
// and the owner id recorded for every accepted request.
package sram_port_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int OWNER_W = 1;
  typedef logic [OWNER_W-1:0] owner_t;

  localparam owner_t OWNER_M0 = 1'b0;
  localparam owner_t OWNER_M1 = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_tag_fifo.sv
// In-order FIFO of owner ids for accepted-but-unanswered requests.
// Head is read combinationally so responses route in the same cycle.
module ot_tag_fifo
  import sram_port_arbiter_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  owner_t        i_push_id,
  input  logic          i_pop,
  output owner_t        o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  owner_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push_en;
  logic            w_pop_en;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  // A pop never frees room for a push in the same cycle.
  assign w_push_en = i_push & ~o_full;
  assign w_pop_en  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_mem[r_wr_ptr] <= i_push_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop_en) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin 2:1 arbiter onto the bridge's SRAM-like data port; grants are
// held until accepted and responses are routed back via the in-order tag FIFO.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int OT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        err
);

  localparam int CW = $clog2(OT_DEPTH) + 1;

  logic          r_lock;
  owner_t        r_lock_id;
  owner_t        r_rr_ptr;
  logic          r_err;

  owner_t        w_grant;
  logic          w_sel_m1;
  logic          w_grant_req;
  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_stall;
  owner_t        w_head;
  logic [CW-1:0] w_count_unused;

  always_comb begin
    if (r_lock) begin
      w_grant = r_lock_id;
    end else if (m0_req && m1_req) begin
      w_grant = r_rr_ptr;
    end else if (m1_req) begin
      w_grant = OWNER_M1;
    end else begin
      w_grant = OWNER_M0;
    end
  end

  assign w_sel_m1    = (w_grant == OWNER_M1);
  assign w_grant_req = w_sel_m1 ? m1_req : m0_req;

  assign s_req    = w_grant_req & ~w_full;
  assign s_wr     = w_sel_m1 ? m1_wr    : m0_wr;
  assign s_size   = w_sel_m1 ? m1_size  : m0_size;
  assign s_wstrb  = w_sel_m1 ? m1_wstrb : m0_wstrb;
  assign s_addr   = w_sel_m1 ? m1_addr  : m0_addr;
  assign s_wdata  = w_sel_m1 ? m1_wdata : m0_wdata;

  assign w_accept = s_req & s_addr_ok;
  assign w_stall  = s_req & ~s_addr_ok;

  assign m0_addr_ok = ~w_sel_m1 & m0_req & s_addr_ok & ~w_full;
  assign m1_addr_ok =  w_sel_m1 & m1_req & s_addr_ok & ~w_full;

  // A response with nothing outstanding is routed nowhere and flagged.
  assign m0_data_ok = s_data_ok & ~w_empty & (w_head == OWNER_M0);
  assign m1_data_ok = s_data_ok & ~w_empty & (w_head == OWNER_M1);
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign err        = r_err;

  ot_tag_fifo #(
    .DEPTH (OT_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_accept),
    .i_push_id (w_grant),
    .i_pop     (s_data_ok),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock    <= 1'b0;
      r_lock_id <= OWNER_M0;
      r_rr_ptr  <= OWNER_M0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_lock   <= 1'b0;
        r_rr_ptr <= ~w_grant;
      end else if (w_stall) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_grant;
      end else if (r_lock && !w_grant_req) begin
        r_lock <= 1'b0;
      end
      if (s_data_ok && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: expected response owners are queued
// as requests are driven and checked when the bridge returns data_ok.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  localparam int OT_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0]  m0_size, m1_size;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic        err;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  logic exp_rr;
  logic g;

  sram_port_arbiter #(.OT_DEPTH(OT_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
    .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
    .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok), .s_rdata(s_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 1'b0; m1_req = 1'b0;
    s_addr_ok = 1'b0; s_data_ok = 1'b0;
  endtask

  // Drive one bridge response and check it lands on the queued owner.
  task automatic respond(input logic [31:0] rd);
    logic owner;
    s_data_ok = 1'b1;
    s_rdata   = rd;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL resp_queue observed=empty expected=entry");
    end else begin
      owner = exp_q.pop_front();
      $display("resp owner=%0d rdata=%h m0_data_ok=%0d m1_data_ok=%0d", owner, rd, m0_data_ok, m1_data_ok);
      chk("resp_m0_data_ok", 32'(m0_data_ok), 32'(owner == 1'b0));
      chk("resp_m1_data_ok", 32'(m1_data_ok), 32'(owner == 1'b1));
      chk("resp_rdata", owner ? m1_rdata : m0_rdata, rd);
    end
    tick();
    s_data_ok = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    m0_wr = 1'b0; m0_size = SZ_BYTE; m0_wstrb = 4'h1; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_wr = 1'b1; m1_size = SZ_WORD; m1_wstrb = 4'hF; m1_addr = 32'h0; m1_wdata = 32'h0;
    s_rdata = 32'h0;
    exp_rr = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_s_req", 32'(s_req), 32'd0);
    chk("rst_m0_addr_ok", 32'(m0_addr_ok), 32'd0);
    chk("rst_m1_addr_ok", 32'(m1_addr_ok), 32'd0);
    chk("rst_data_ok", 32'({m0_data_ok, m1_data_ok}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();

    // Single m0 read, response three cycles later
    m0_req = 1'b1; m0_addr = 32'h1000; s_addr_ok = 1'b1;
    @(negedge clk);
    $display("accept m0 addr=%h addr_ok=%0d", s_addr, m0_addr_ok);
    chk("t1_m0_addr_ok", 32'(m0_addr_ok), 32'd1);
    chk("t1_s_addr", s_addr, 32'h1000);
    chk("t1_s_wr", 32'(s_wr), 32'd0);
    exp_q.push_back(1'b0);
    exp_rr = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t1_quiet_data_ok", 32'({m0_data_ok, m1_data_ok}), 32'd0);
      tick();
    end
    respond(32'hDEADBEEF);

    // Both masters request continuously: alternate until the FIFO fills
    m0_req = 1'b1; m0_addr = 32'h2000; m0_wdata = 32'h0000_00A0;
    m1_req = 1'b1; m1_addr = 32'h3000; m1_wdata = 32'h1111_2222;
    s_addr_ok = 1'b1;
    for (int i = 0; i < OT_DEPTH + 2; i++) begin
      if (i == OT_DEPTH) begin
        s_data_ok = 1'b1;
        s_rdata   = 32'hA5A5_0001;
      end
      @(negedge clk);
      if (i == OT_DEPTH) begin
        $display("full cycle s_req=%0d m0_addr_ok=%0d m1_addr_ok=%0d", s_req, m0_addr_ok, m1_addr_ok);
        chk("full_s_req", 32'(s_req), 32'd0);
        chk("full_addr_ok", 32'({m0_addr_ok, m1_addr_ok}), 32'd0);
        g = exp_q.pop_front();
        chk("full_pop_m0_data_ok", 32'(m0_data_ok), 32'(g == 1'b0));
        chk("full_pop_m1_data_ok", 32'(m1_data_ok), 32'(g == 1'b1));
      end else begin
        g = exp_rr;
        $display("accept m%0d addr=%h m0_addr_ok=%0d m1_addr_ok=%0d", g, s_addr, m0_addr_ok, m1_addr_ok);
        chk("rr_m0_addr_ok", 32'(m0_addr_ok), 32'(g == 1'b0));
        chk("rr_m1_addr_ok", 32'(m1_addr_ok), 32'(g == 1'b1));
        chk("rr_s_addr", s_addr, g ? 32'h3000 : 32'h2000);
        chk("rr_s_wdata", s_wdata, g ? 32'h1111_2222 : 32'h0000_00A0);
        chk("rr_s_size", 32'(s_size), g ? 32'(SZ_WORD) : 32'(SZ_BYTE));
        chk("rr_s_wstrb", 32'(s_wstrb), g ? 32'hF : 32'h1);
        exp_q.push_back(g);
        exp_rr = ~g;
      end
      tick();
      s_data_ok = 1'b0;
    end
    idle();
    for (int i = 0; i < OT_DEPTH; i++) respond(32'hC0DE_0000 + 32'(i));

    // m1 locked through a 4-cycle stall while m0 also requests
    m1_req = 1'b1; m1_addr = 32'h4000; m0_addr = 32'h5000;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) m0_req = 1'b1;
      @(negedge clk);
      $display("stall cycle=%0d s_req=%0d s_addr=%h", i, s_req, s_addr);
      chk("lock_s_req", 32'(s_req), 32'd1);
      chk("lock_s_addr", s_addr, 32'h4000);
      chk("lock_addr_ok", 32'({m0_addr_ok, m1_addr_ok}), 32'd0);
      tick();
    end
    s_addr_ok = 1'b1;
    @(negedge clk);
    chk("lock_m1_accept", 32'(m1_addr_ok), 32'd1);
    chk("lock_m0_wait", 32'(m0_addr_ok), 32'd0);
    exp_q.push_back(1'b1);
    tick();
    m1_req = 1'b0;
    @(negedge clk);
    $display("accept m0 after lock addr=%h addr_ok=%0d", s_addr, m0_addr_ok);
    chk("lock_m0_next", 32'(m0_addr_ok), 32'd1);
    chk("lock_m0_addr", s_addr, 32'h5000);
    exp_q.push_back(1'b0);
    tick();
    idle();

    // Same-cycle push and pop at count 2
    m1_req = 1'b1; m1_addr = 32'h6000; s_addr_ok = 1'b1;
    s_data_ok = 1'b1; s_rdata = 32'h1234_5678;
    @(negedge clk);
    g = exp_q.pop_front();
    $display("push+pop head=%0d m0_data_ok=%0d m1_data_ok=%0d m1_addr_ok=%0d", g, m0_data_ok, m1_data_ok, m1_addr_ok);
    chk("pp_m1_addr_ok", 32'(m1_addr_ok), 32'd1);
    chk("pp_m0_data_ok", 32'(m0_data_ok), 32'(g == 1'b0));
    chk("pp_m1_data_ok", 32'(m1_data_ok), 32'(g == 1'b1));
    chk("pp_rdata", m1_rdata, 32'h1234_5678);
    exp_q.push_back(1'b1);
    tick();
    idle();
    respond(32'hBEEF_0001);
    respond(32'hBEEF_0002);

    // Response with the FIFO empty
    s_data_ok = 1'b1;
    @(negedge clk);
    chk("empty_data_ok", 32'({m0_data_ok, m1_data_ok}), 32'd0);
    chk("empty_err_before", 32'(err), 32'd0);
    tick();
    s_data_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m0_req = 1'b1; m0_addr = 32'h7000 + 32'(i); s_addr_ok = 1'b1;
      @(negedge clk);
      $display("sticky err=%0d accept m0_addr_ok=%0d", err, m0_addr_ok);
      chk("err_sticky", 32'(err), 32'd1);
      chk("err_accept", 32'(m0_addr_ok), 32'd1);
      tick();
    end
    idle();

    // Reset drops outstanding tags and err
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("post_rst_err", 32'(err), 32'd0);
    s_data_ok = 1'b1;
    @(negedge clk);
    $display("post reset response m0_data_ok=%0d m1_data_ok=%0d", m0_data_ok, m1_data_ok);
    chk("post_rst_count_empty", 32'({m0_data_ok, m1_data_ok}), 32'd0);
    tick();
    s_data_ok = 1'b0;
    @(negedge clk);
    chk("post_rst_err_again", 32'(err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
